// File: rtl/gj_axis_uart_rx.sv
// gj_axis_uart_rx -- UART bit-level receiver feeding the AXIS packet assembler.
//
// Oversamples uart_rxd 16x, deframes start/8 data/optional parity/1-2 stop bits
// and emits one byte per frame as a one-cycle valid pulse (no backpressure).
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   baud_div        clocks per sample tick (0 behaves as 1); bit = 16 sample ticks
//   parity_en       parity bit present after data
//   parity_odd      1 = odd parity, 0 = even
//   stop2           check two stop bits
//   uart_rxd        asynchronous serial line, idle high
//   rx_tvalid       one-cycle pulse per received frame
//   rx_tdata        received byte (LSB first on the wire), held until next pulse
//   rx_tuser        parity or framing error for this byte (qualified by rx_tvalid)
//   bit_tick        free-running pulse once per bit time (assembler clk_en)
//   err_parity      sticky parity error flag
//   err_frame       sticky framing error flag
module gj_axis_uart_rx #(
  parameter int DIV_W       = 16,
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             uart_rxd,
  output logic             rx_tvalid,
  output logic [7:0]       rx_tdata,
  output logic             rx_tuser,
  output logic             bit_tick,
  output logic             err_parity,
  output logic             err_frame
);

  localparam logic [3:0] PH_LAST = 4'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRK} stateT;
  stateT state, stateNext;

  logic [SYNC_STAGES-1:0] syncQ;
  logic [SYNC_STAGES-1:0] vldPipe;   // marks synchronizer stages holding real line samples
  logic                   rxS, rxPrev, fallEdge;

  logic [DIV_W-1:0] divCnt, reload;
  logic             sampleTick;
  logic [3:0]       phase, phNext, bitPh;
  logic             s7, s8, decBit, decide, bitEnd;

  logic [7:0] shiftReg;
  logic [2:0] dataCnt;
  logic       parErr, emit, frmNow;

  assign rxS = syncQ[SYNC_STAGES-1];
  // rxPrev only goes high once a genuine high has been synchronized, so a line
  // already low when reset releases never looks like a start edge.
  assign fallEdge = rxPrev & ~rxS;

  assign reload     = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign sampleTick = (divCnt == '0);

  // phase counts sample ticks since the bit started; a tick is "at phase p"
  // when it brings the count to p.
  assign phNext = phase + 4'd1;
  assign decide = sampleTick && (phNext == 4'd9);
  assign bitEnd = sampleTick && (phase == PH_LAST);
  assign decBit = (s7 & s8) | (s7 & rxS) | (s8 & rxS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    emit      = 1'b0;
    frmNow    = 1'b0;
    case (state)
      IDLE:   if (fallEdge) stateNext = START;
      START: begin
        if (decide && decBit) stateNext = IDLE;   // glitch, not a start bit
        else if (bitEnd)      stateNext = DATA;
      end
      DATA:   if (bitEnd && dataCnt == 3'd7) stateNext = parity_en ? PARITY : STOP1;
      PARITY: if (bitEnd) stateNext = STOP1;
      STOP1: begin
        if (decide) begin
          if (!decBit) begin
            emit = 1'b1; frmNow = 1'b1; stateNext = BRK;
          end else if (!stop2) begin
            emit = 1'b1; stateNext = IDLE;
          end
        end else if (bitEnd && stop2) begin
          stateNext = STOP2;
        end
      end
      STOP2: begin
        if (decide) begin
          emit = 1'b1;
          if (!decBit) begin frmNow = 1'b1; stateNext = BRK; end
          else         stateNext = IDLE;
        end
      end
      BRK:     if (rxS) stateNext = IDLE;     // wait out a held-low line
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syncQ      <= '1;
      vldPipe    <= '0;
      rxPrev     <= 1'b0;
      divCnt     <= '0;
      phase      <= '0;
      bitPh      <= '0;
      bit_tick   <= 1'b0;
      s7         <= 1'b0;
      s8         <= 1'b0;
      shiftReg   <= '0;
      dataCnt    <= '0;
      parErr     <= 1'b0;
      rx_tvalid  <= 1'b0;
      rx_tdata   <= '0;
      rx_tuser   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      syncQ   <= {syncQ[SYNC_STAGES-2:0], uart_rxd};
      vldPipe <= {vldPipe[SYNC_STAGES-2:0], 1'b1};
      rxPrev  <= vldPipe[SYNC_STAGES-1] & rxS;

      // Start edge realigns the sample grid so phase 8 lands mid-bit.
      if (state == IDLE && fallEdge) begin
        divCnt <= reload;
        phase  <= '0;
      end else begin
        divCnt <= sampleTick ? reload : divCnt - DIV_W'(1);
        if (sampleTick) phase <= phNext;
      end

      // bit_tick has its own tick count and is never realigned.
      if (sampleTick) bitPh <= bitPh + 4'd1;
      bit_tick <= sampleTick && (bitPh == 4'hF);

      if (sampleTick && phNext == 4'd7) s7 <= rxS;
      if (sampleTick && phNext == 4'd8) s8 <= rxS;

      if (state == IDLE) begin
        dataCnt <= '0;
        parErr  <= 1'b0;
      end
      if (state == DATA && decide) shiftReg <= {decBit, shiftReg[7:1]};
      if (state == DATA && bitEnd) dataCnt  <= dataCnt + 3'd1;
      if (state == PARITY && decide) parErr <= ^{shiftReg, decBit, parity_odd};

      rx_tvalid <= emit;
      if (emit) begin
        rx_tdata <= shiftReg;
        rx_tuser <= parErr | frmNow;
        if (parErr) err_parity <= 1'b1;
        if (frmNow) err_frame  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gj_axis_uart_rx.sv
// Directed bench for gj_axis_uart_rx at baud_div=4 (64 clocks per bit).
// Expected bytes come from what the bench puts on the wire; a queue holds
// the expected byte/error/latency per frame and one negedge process checks
// every rx_tvalid pulse and the sticky flags against it.
module tb_gj_axis_uart_rx;

  localparam int BD   = 4;
  localparam int BIT  = 16 * BD;
  localparam int SYNC = 2;
  localparam int TOL  = BD + 2;   // one sample tick plus edge/measurement quantization

  logic        clk, rst;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2, uart_rxd;
  logic        rx_tvalid, rx_tuser, bit_tick, err_parity, err_frame;
  logic [7:0]  rx_tdata;

  gj_axis_uart_rx #(.DIV_W(16), .OVS(16), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .stop2(stop2), .uart_rxd(uart_rxd),
    .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata), .rx_tuser(rx_tuser),
    .bit_tick(bit_tick), .err_parity(err_parity), .err_frame(err_frame)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       perr;
    logic       ferr;
    int         t0;
    int         nom;
  } expT;

  expT  expQ[$];
  int   pulseCyc[$];
  int   vectors = 0, miscompares = 0, pulseCnt = 0;
  logic mErrPar = 1'b0, mErrFrm = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Nominal latency from the start-bit edge: (bits up to mid last stop) * bit + sync + 2.
  function automatic int nomLat(input int nBits);
    return nBits * BIT - BIT / 2 + SYNC + 2;
  endfunction

  // Compare process: every rx_tvalid consumes one expectation; sticky flags
  // follow the model every cycle.
  initial begin
    expT e;
    int  lat;
    forever begin
      @(negedge clk);
      if (rst) begin
        mErrPar = 1'b0;
        mErrFrm = 1'b0;
      end else begin
        if (rx_tvalid) begin
          pulseCnt++;
          pulseCyc.push_back(cyc);
          check("pulse_expected", 32'(expQ.size() > 0), 1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("rx_tdata", rx_tdata, e.data);
            check("rx_tuser", rx_tuser, e.user);
            lat = cyc - e.t0;
            vectors++;
            if (lat < e.nom - TOL || lat > e.nom + TOL) begin
              miscompares++;
              $display("FAIL latency: got %0d, required %0d +/- %0d", lat, e.nom, TOL);
            end
            mErrPar = mErrPar | e.perr;
            mErrFrm = mErrFrm | e.ferr;
          end
        end
        check("err_parity", err_parity, mErrPar);
        check("err_frame", err_frame, mErrFrm);
      end
    end
  end

  // Drive one frame starting at a negedge; usePar/parBit give the parity bit on the wire.
  task automatic sendFrame(input logic [7:0] d, input bit usePar, input bit parBit,
                           input bit twoStop, input bit expectIt);
    expT e;
    e.data = d;
    // even: XOR of data+parity must be 0; odd: must be 1
    e.perr = usePar && ((^d ^ parBit) != parity_odd);
    e.ferr = 1'b0;
    e.user = e.perr;
    e.t0   = cyc;
    e.nom  = nomLat(1 + 8 + (usePar ? 1 : 0) + (twoStop ? 2 : 1));
    if (expectIt) expQ.push_back(e);
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (usePar) begin
      uart_rxd = parBit;
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = 1'b1;
    repeat (twoStop ? 2 * BIT : BIT) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("outstanding_frames", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic measureBitTick(input int expPeriod, input int nIntervals);
    int last = -1;
    int budget;
    for (int k = 0; k <= nIntervals; k++) begin
      budget = 0;
      while (!bit_tick && budget < 4 * expPeriod) begin
        @(negedge clk);
        budget++;
      end
      check("bit_tick_seen", bit_tick, 1);
      if (!bit_tick) return;
      if (last >= 0) check("bit_tick_period", cyc - last, expPeriod);
      last = cyc;
      @(negedge clk);
    end
  endtask

  initial begin
    expT ef;
    int  p0, i0;
    rst = 1'b1; baud_div = 16'(BD); parity_en = 1'b0; parity_odd = 1'b0;
    stop2 = 1'b0; uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tvalid", rx_tvalid, 0);
    check("reset_tdata", rx_tdata, 0);
    check("reset_tuser", rx_tuser, 0);
    check("reset_err_parity", err_parity, 0);
    check("reset_err_frame", err_frame, 0);
    check("reset_bit_tick", bit_tick, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // bit_tick cadence, including baud_div=0 behaving as 1
    measureBitTick(BIT, 3);
    baud_div = 16'd0;
    repeat (100) @(negedge clk);
    measureBitTick(16, 4);
    baud_div = 16'(BD);
    repeat (200) @(negedge clk);
    measureBitTick(BIT, 2);

    // 8N1 0xA5
    p0 = pulseCnt;
    sendFrame(8'hA5, 0, 0, 0, 1);
    repeat (50) @(negedge clk);
    drain(2000);
    check("a5_pulses", pulseCnt - p0, 1);
    check("a5_data_literal", rx_tdata, 8'hA5);

    // even parity: 0x03 with parity bit 1 is an error, then a clean 0x03
    parity_en = 1'b1; parity_odd = 1'b0;
    sendFrame(8'h03, 1, 1, 0, 1);
    repeat (50) @(negedge clk);
    drain(2000);
    check("par_err_flag_literal", err_parity, 1);
    sendFrame(8'h03, 1, 0, 0, 1);
    repeat (50) @(negedge clk);
    drain(2000);
    check("par_flag_sticky_literal", err_parity, 1);
    check("par_data_literal", rx_tdata, 8'h03);
    parity_en = 1'b0;

    // 20-clock glitch is rejected, next frame still lands
    p0 = pulseCnt;
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_no_pulse", pulseCnt - p0, 0);
    sendFrame(8'h5A, 0, 0, 0, 1);
    repeat (50) @(negedge clk);
    drain(2000);
    check("glitch_next_pulses", pulseCnt - p0, 1);
    check("glitch_next_data_literal", rx_tdata, 8'h5A);

    // line held low: one framing-error byte, then silence
    p0 = pulseCnt;
    ef.data = 8'h00; ef.user = 1'b1; ef.perr = 1'b0; ef.ferr = 1'b1;
    ef.t0 = cyc; ef.nom = nomLat(10);
    expQ.push_back(ef);
    uart_rxd = 1'b0;
    repeat (2000) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (1500) @(negedge clk);
    drain(10);
    check("break_pulses", pulseCnt - p0, 1);
    check("break_data_literal", rx_tdata, 8'h00);
    check("break_err_frame_literal", err_frame, 1);

    // back-to-back 8N2 frames with no idle gap
    stop2 = 1'b1;
    p0 = pulseCnt;
    i0 = pulseCyc.size();
    sendFrame(8'h00, 0, 0, 1, 1);
    sendFrame(8'hFF, 0, 0, 1, 1);
    sendFrame(8'h55, 0, 0, 1, 1);
    repeat (50) @(negedge clk);
    drain(2000);
    check("b2b_pulses", pulseCnt - p0, 3);
    if (pulseCyc.size() >= i0 + 3) begin
      check("b2b_spacing_1", pulseCyc[i0+1] - pulseCyc[i0], 704);
      check("b2b_spacing_2", pulseCyc[i0+2] - pulseCyc[i0+1], 704);
    end
    check("b2b_last_data_literal", rx_tdata, 8'h55);
    stop2 = 1'b0;

    // reset three bits into 0x81 (line low through data bits 1-6)
    p0 = pulseCnt;
    fork
      sendFrame(8'h81, 0, 0, 0, 0);
      begin
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (300) @(negedge clk);
    check("rst_no_pulse", pulseCnt - p0, 0);
    check("rst_err_parity_literal", err_parity, 0);
    check("rst_err_frame_literal", err_frame, 0);
    sendFrame(8'h7E, 0, 0, 0, 1);
    repeat (50) @(negedge clk);
    drain(2000);
    check("rst_next_pulses", pulseCnt - p0, 1);
    check("rst_next_data_literal", rx_tdata, 8'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
